// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI serial-SRAM responder.
package spi_sram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_PAGE  = 2'b10;
  localparam logic [7:0] MODE_RESET = 8'h40;
  localparam int unsigned PAGE_AW   = 5;

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CMD_LAST  = 5'd7;
  localparam logic [CNT_W-1:0] ADDR_LAST = 5'd23;
  localparam logic [CNT_W-1:0] BYTE_LAST = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes sclk, cs and MOSI into clk and emits one-clk edge pulses.
// Edge pulses and the MOSI sample are registered together so they stay aligned.
module spi_pin_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic cs_i,
  input  logic mosi_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic mosi_o
);

  logic [STAGES-1:0] sclk_sq, cs_sq, mosi_sq;
  logic              sclk_prev_q, cs_prev_q;

  // cs chain resets low so a held-low cs after reset never looks like a new frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sq     <= '0;
      cs_sq       <= '0;
      mosi_sq     <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_rise_o <= 1'b0;
      sclk_fall_o <= 1'b0;
      cs_fall_o   <= 1'b0;
      cs_rise_o   <= 1'b0;
      mosi_o      <= 1'b0;
    end else begin
      sclk_sq     <= {sclk_sq[STAGES-2:0], sclk_i};
      cs_sq       <= {cs_sq[STAGES-2:0], cs_i};
      mosi_sq     <= {mosi_sq[STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sq[STAGES-1];
      cs_prev_q   <= cs_sq[STAGES-1];
      sclk_rise_o <= sclk_sq[STAGES-1] & ~sclk_prev_q;
      sclk_fall_o <= ~sclk_sq[STAGES-1] & sclk_prev_q;
      cs_rise_o   <= cs_sq[STAGES-1] & ~cs_prev_q;
      cs_fall_o   <= ~cs_sq[STAGES-1] & cs_prev_q;
      mosi_o      <= mosi_sq[STAGES-1];
    end
  end

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave answering 23-series READ/WRITE from an internal byte RAM.
// Define SPI_SRAM_MODE_REG_EN to add RDSR/WRSR and byte/page/sequential addressing.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              MOSI,
  output logic              MISO,
  output logic              miso_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic              bad_inst,
  input  logic [MEM_AW-1:0] bd_addr,
  output logic [7:0]        bd_data
);

  localparam int unsigned DEPTH = 1 << MEM_AW;

  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, mosi_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] addr_q, addr_d, fetch_addr_c;
  logic              rd_q, rd_d, sr_q, sr_d, done_q, done_d;
  logic [7:0]        tx_q, tx_d, rd_byte_q, rd_src_c, shift_in_c, status_c;
  logic              miso_q, miso_d, oe_q, oe_d, busy_q, busy_d;
  logic              wr_strobe_q, wr_strobe_d, bad_q, bad_d;
  logic              mem_we_c, fetch_en_c, drop_c;
  logic [1:0]        amode_c;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        bd_data_q;
`ifdef SPI_SRAM_MODE_REG_EN
  logic [7:0]        mode_q, mode_d;
`endif

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst         (rst),
    .sclk_i      (sclk),
    .cs_i        (cs),
    .mosi_i      (MOSI),
    .sclk_rise_o (sclk_rise_s),
    .sclk_fall_o (sclk_fall_s),
    .cs_fall_o   (cs_fall_s),
    .cs_rise_o   (cs_rise_s),
    .mosi_o      (mosi_s)
  );

  function automatic logic [MEM_AW-1:0] addr_inc(input logic [MEM_AW-1:0] a,
                                                 input logic [1:0] m);
    logic [MEM_AW-1:0] n;
    n = a + MEM_AW'(1);
    if (m == MODE_PAGE) n = {a[MEM_AW-1:PAGE_AW], n[PAGE_AW-1:0]};
    return n;
  endfunction

`ifdef SPI_SRAM_MODE_REG_EN
  assign amode_c  = mode_q[7:6];
  assign status_c = mode_q;
`else
  assign amode_c  = MODE_RESET[7:6];
  assign status_c = 8'h00;
`endif

  assign shift_in_c = {shift_q, mosi_s};
  assign drop_c     = done_q && (amode_c == MODE_BYTE);
  assign rd_src_c   = drop_c ? 8'h00 : (sr_q ? status_c : rd_byte_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; cs_rise wins over any same-clk sclk edge
  always_comb begin
    state_d = state_q;
    if (cs_rise_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall_s) state_d = ST_CMD;
        ST_CMD: begin
          if (sclk_rise_s && cnt_q == CMD_LAST) begin
            case (shift_in_c)
              OP_READ, OP_WRITE: state_d = ST_ADDR;
`ifdef SPI_SRAM_MODE_REG_EN
              OP_RDSR: state_d = ST_RD_DATA;
              OP_WRSR: state_d = ST_WR_DATA;
`else
              OP_RDSR, OP_WRSR: state_d = ST_IGNORE;
`endif
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (sclk_rise_s && cnt_q == ADDR_LAST) state_d = rd_q ? ST_RD_DATA : ST_WR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    sr_d         = sr_q;
    done_d       = done_q;
    tx_d         = tx_q;
    miso_d       = (state_d == ST_RD_DATA) ? miso_q : 1'b0;
    oe_d         = (state_d == ST_RD_DATA);
    busy_d       = (state_d != ST_IDLE);
    wr_strobe_d  = 1'b0;
    bad_d        = 1'b0;
    mem_we_c     = 1'b0;
    fetch_en_c   = 1'b0;
    fetch_addr_c = addr_q;
`ifdef SPI_SRAM_MODE_REG_EN
    mode_d       = mode_q;
`endif
    if (!cs_rise_s) begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall_s) begin
            cnt_d  = '0;
            rd_d   = 1'b0;
            sr_d   = 1'b0;
            done_d = 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise_s) begin
            shift_d = shift_in_c[6:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CMD_LAST) begin
              cnt_d = '0;
              case (shift_in_c)
                OP_READ:  rd_d = 1'b1;
                OP_WRITE: rd_d = 1'b0;
`ifdef SPI_SRAM_MODE_REG_EN
                OP_RDSR, OP_WRSR: sr_d = 1'b1;
`endif
                default:  bad_d = 1'b1;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise_s) begin
            addr_d = {addr_q[MEM_AW-2:0], mosi_s};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == ADDR_LAST) begin
              cnt_d        = '0;
              fetch_en_c   = rd_q;
              fetch_addr_c = addr_d;
            end
          end
        end
        ST_RD_DATA: begin
          if (sclk_fall_s) begin
            if (cnt_q == '0) begin
              miso_d = rd_src_c[7];
              tx_d   = {rd_src_c[6:0], 1'b0};
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            // Last bit of the byte is out: advance and prefetch before the next fall
            if (cnt_q == BYTE_LAST) begin
              cnt_d  = '0;
              done_d = 1'b1;
              if (!sr_q) begin
                addr_d       = addr_inc(addr_q, amode_c);
                fetch_en_c   = 1'b1;
                fetch_addr_c = addr_d;
              end
            end
          end
        end
        ST_WR_DATA: begin
          if (sclk_rise_s) begin
            shift_d = shift_in_c[6:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == BYTE_LAST) begin
              cnt_d  = '0;
              done_d = 1'b1;
              if (sr_q) begin
`ifdef SPI_SRAM_MODE_REG_EN
                mode_d = shift_in_c;
`endif
              end else if (!drop_c) begin
                mem_we_c    = 1'b1;
                wr_strobe_d = 1'b1;
                addr_d      = addr_inc(addr_q, amode_c);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      sr_q        <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      bad_q       <= 1'b0;
`ifdef SPI_SRAM_MODE_REG_EN
      mode_q      <= MODE_RESET;
`endif
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      sr_q        <= sr_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      bad_q       <= bad_d;
`ifdef SPI_SRAM_MODE_REG_EN
      mode_q      <= mode_d;
`endif
    end
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we_c)   mem_q[addr_q] <= shift_in_c;
    if (fetch_en_c) rd_byte_q     <= mem_q[fetch_addr_c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bd_data_q <= '0;
    else     bd_data_q <= mem_q[bd_addr];
  end

  assign MISO      = miso_q;
  assign miso_oe   = oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign bad_inst  = bad_q;
  assign bd_data   = bd_data_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: table of SPI transactions plus reset corner cases.
module tb_spi_sram_responder;

  localparam int unsigned MEM_AW = 10;
  localparam int HALF = 80;

  typedef struct {
    logic [7:0]  op;
    bit          has_addr;
    logic [23:0] addr;
    int          ndbits;
    logic [15:0] wdata;
    bit          is_read;
    logic [15:0] exp_rx;
    int          exp_str;
    int          exp_bad;
  } vec_t;

  typedef struct {
    logic [MEM_AW-1:0] addr;
    logic [7:0]        data;
  } bd_t;

  logic clk = 1'b0;
  logic rst, sclk, cs, mosi, miso, miso_oe, busy, wr_strobe, bad_inst;
  logic [MEM_AW-1:0] bd_addr;
  logic [7:0]        bd_data;

  int checks = 0, failures = 0;
  int str_cnt = 0, bad_cnt = 0, miso_bad = 0;

  always #5 clk = ~clk;

  spi_sram_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .MOSI      (mosi),
    .MISO      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .bad_inst  (bad_inst),
    .bd_addr   (bd_addr),
    .bd_data   (bd_data)
  );

  always @(negedge clk) begin
    if (wr_strobe) str_cnt++;
    if (bad_inst)  bad_cnt++;
    if (!miso_oe && miso) miso_bad++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic got, output logic oe);
    mosi = b;
    #HALF sclk = 1'b1;
    got = miso;
    oe  = miso_oe;
    #HALF sclk = 1'b0;
  endtask

  task automatic txn(input vec_t v, output logic [15:0] rx, output bit ctl_ok);
    logic got, oe;
    rx = '0;
    ctl_ok = 1'b1;
    cs = 1'b0;
    #40;
    for (int i = 7; i >= 0; i--) begin
      send_bit(v.op[i], got, oe);
      if (oe !== 1'b0) ctl_ok = 1'b0;
    end
    if (busy !== 1'b1) ctl_ok = 1'b0;
    if (v.has_addr) begin
      for (int i = 23; i >= 0; i--) begin
        send_bit(v.addr[i], got, oe);
        if (oe !== 1'b0) ctl_ok = 1'b0;
      end
    end
    for (int i = 0; i < v.ndbits; i++) begin
      send_bit(v.wdata[15-i], got, oe);
      rx[15-i] = got;
      if (oe !== v.is_read) ctl_ok = 1'b0;
    end
    #40 cs = 1'b1;
    #80;
    if (miso_oe !== 1'b0 || busy !== 1'b0 || miso !== 1'b0) ctl_ok = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s0, b0;
    logic [15:0] rx;
    bit ok;
    s0 = str_cnt;
    b0 = bad_cnt;
    txn(v, rx, ok);
    chk({tag, "_wr_strobe"}, 32'(str_cnt - s0), 32'(v.exp_str));
    chk({tag, "_bad_inst"},  32'(bad_cnt - b0), 32'(v.exp_bad));
    chk({tag, "_miso"},      32'(rx),           32'(v.exp_rx));
    chk({tag, "_oe_busy"},   32'(ok),           32'd1);
  endtask

  task automatic bd_check(input logic [MEM_AW-1:0] a, input logic [7:0] exp);
    bd_addr = a;
    #10;
    chk($sformatf("bd_%03h", a), 32'(bd_data), 32'(exp));
  endtask

  vec_t vecs[12];
  bd_t  bds[6];

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hdr;
    logic        got, oe;
    logic [15:0] rx;
    bit          ok;
    vec_t        rv;

    //          op     addr? addr        nbits wdata      rd    exp_rx     str bad
    vecs[0]  = '{8'h02, 1'b1, 24'h000010, 16, 16'hA53C, 1'b0, 16'h0000, 2, 0};
    vecs[1]  = '{8'h03, 1'b1, 24'h000010, 16, 16'h0000, 1'b1, 16'hA53C, 0, 0};
    vecs[2]  = '{8'h02, 1'b1, 24'h0003FF, 16, 16'h1122, 1'b0, 16'h0000, 2, 0};
    vecs[3]  = '{8'h03, 1'b1, 24'h0003FF, 16, 16'h0000, 1'b1, 16'h1122, 0, 0};
    vecs[4]  = '{8'h02, 1'b1, 24'hABCC05,  8, 16'h7700, 1'b0, 16'h0000, 1, 0};
    vecs[5]  = '{8'h03, 1'b1, 24'h000005,  8, 16'h0000, 1'b1, 16'h7700, 0, 0};
    vecs[6]  = '{8'h02, 1'b1, 24'h000020,  8, 16'h5A00, 1'b0, 16'h0000, 1, 0};
    vecs[7]  = '{8'h02, 1'b1, 24'h000020,  5, 16'hF800, 1'b0, 16'h0000, 0, 0};
    vecs[8]  = '{8'h03, 1'b1, 24'h000020,  8, 16'h0000, 1'b1, 16'h5A00, 0, 0};
    vecs[9]  = '{8'h9F, 1'b0, 24'h000000,  8, 16'hFF00, 1'b0, 16'h0000, 0, 1};
    vecs[10] = '{8'h00, 1'b0, 24'h000000,  8, 16'hFF00, 1'b0, 16'h0000, 0, 1};
    vecs[11] = '{8'h03, 1'b1, 24'h000010,  8, 16'h0000, 1'b1, 16'hA500, 0, 0};

    bds[0] = '{10'h010, 8'hA5};
    bds[1] = '{10'h011, 8'h3C};
    bds[2] = '{10'h3FF, 8'h11};
    bds[3] = '{10'h000, 8'h22};
    bds[4] = '{10'h005, 8'h77};
    bds[5] = '{10'h020, 8'h5A};

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; bd_addr = '0;
    #30;
    chk("rst_miso",      32'(miso),      32'd0);
    chk("rst_miso_oe",   32'(miso_oe),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_bad_inst",  32'(bad_inst),  32'd0);
    chk("rst_bd_data",   32'(bd_data),   32'd0);
    rst = 1'b0;
    #100;
    chk("idle_busy",    32'(busy),    32'd0);
    chk("idle_miso_oe", 32'(miso_oe), 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    for (int i = 0; i < 6; i++) bd_check(bds[i].addr, bds[i].data);

    // Reset in the middle of a read data phase, cs still low
    hdr = {8'h03, 24'h000010};
    cs = 1'b0;
    #40;
    for (int i = 31; i >= 0; i--) send_bit(hdr[i], got, oe);
    for (int i = 0; i < 3; i++) send_bit(1'b0, got, oe);
    chk("midrst_pre_oe", 32'(miso_oe), 32'd1);
    rst = 1'b1;
    #30;
    chk("midrst_oe",   32'(miso_oe), 32'd0);
    chk("midrst_miso", 32'(miso),    32'd0);
    chk("midrst_busy", 32'(busy),    32'd0);
    rst = 1'b0;
    #60;
    chk("midrst_after_busy", 32'(busy), 32'd0);
    cs = 1'b1;
    #80;
    rv = '{8'h03, 1'b1, 24'h000010, 8, 16'h0000, 1'b1, 16'hA500, 0, 0};
    run_vec(rv, "recover");

`ifdef SPI_SRAM_MODE_REG_EN
    rv = '{8'h01, 1'b0, 24'h000000,  8, 16'h8000, 1'b0, 16'h0000, 0, 0};
    run_vec(rv, "wrsr");
    rv = '{8'h02, 1'b1, 24'h00001F, 16, 16'h0102, 1'b0, 16'h0000, 2, 0};
    run_vec(rv, "page_wr");
    rv = '{8'h05, 1'b0, 24'h000000, 16, 16'h0000, 1'b1, 16'h8080, 0, 0};
    run_vec(rv, "rdsr");
    bd_check(10'h01F, 8'h01);
    bd_check(10'h000, 8'h02);
`endif

    chk("miso_zero_when_not_oe", 32'(miso_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
